// File: rtl/obj_res_arb_if.sv
// -----------------------------------------------------------------------------
// obj_res_arb_if
//   AXI-stream style bundle used for the obj_fc result streams and for the
//   merged output of obj_res_arb.
//   Signals:
//     tdata  [DW-1:0]  payload
//     tvalid           producer has a beat
//     tready           consumer takes the beat
//     tlast            end of packet
//     tuser  [UW-1:0]  {sof,eof,sol,eol}, passed through untouched
//     tid    [1:0]     source id (only meaningful on the merged stream)
//   Modports:
//     master  stream producer (drives payload, samples tready)
//     slave   stream consumer (samples payload, drives tready; tid not used)
// -----------------------------------------------------------------------------
interface obj_res_arb_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned UW = 4
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [UW-1:0] tuser;
  logic [1:0]    tid;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    output tid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/obj_res_arb.sv
// -----------------------------------------------------------------------------
// obj_res_arb
//   Packet-aware arbiter merging the obj_fc result streams (side, shift,
//   angle) into one stream for the host DMA/register path. One source is
//   granted per packet and held until its tlast (or a forced end after
//   MAXLEN beats). Every output beat carries the id of its source.
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     s_side          side stream in   (tid 0)
//     s_shift         shift stream in  (tid 1)
//     s_angle         angle stream in  (tid 2)
//     m_res           merged stream out (tdata/tvalid/tlast/tuser/tid, tready in)
//     reg_cfg         [0] enable, [1] mode (0 round-robin, 1 fixed side>shift>angle),
//                     [2] clear counters/errors (level)
//     reg_cnt         [31:0] side beats, [63:32] shift beats,
//                     [95:64] angle beats, [127:96] packets out
//     reg_sta         [1:0] granted tid (3 = none), [2] busy, [3] output stall
//     reg_err         [0] MAXLEN truncation (sticky), [1] counter wrap (sticky)
// -----------------------------------------------------------------------------
module obj_res_arb #(
  parameter int unsigned DW     = 16,
  parameter int unsigned UW     = 4,
  parameter int unsigned REG_DW = 32,
  parameter int unsigned MAXLEN = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  obj_res_arb_if.slave          s_side,
  obj_res_arb_if.slave          s_shift,
  obj_res_arb_if.slave          s_angle,
  obj_res_arb_if.master         m_res,
  input  logic [REG_DW-1:0]     reg_cfg,
  output logic [REG_DW*4-1:0]   reg_cnt,
  output logic [REG_DW-1:0]     reg_sta,
  output logic [REG_DW-1:0]     reg_err
);

  localparam int unsigned CW       = $clog2(MAXLEN);
  localparam logic [1:0]  TID_NONE = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  grant;
  logic [1:0]  grant_next;
  logic [1:0]  rr_ptr;
  logic [1:0]  rr_next;
  logic [1:0]  pick;
  logic        found;

  logic        cfg_en;
  logic        cfg_fixed;
  logic        cfg_clr;
  logic        unused_cfg;

  logic [2:0]  req_valid;

  logic          g_valid;
  logic [DW-1:0] g_data;
  logic [UW-1:0] g_user;
  logic          g_last;

  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [UW-1:0] out_user;
  logic          out_last;
  logic [1:0]    out_tid;

  logic          busy;
  logic          out_free;
  logic          accept;
  logic          beat_cap;
  logic          pkt_end;
  logic          trunc;
  logic [CW-1:0] beat_cnt;

  logic [REG_DW-1:0] cnt [4];
  logic [3:0]        inc;
  logic              err_trunc;
  logic              err_wrap;

  assign cfg_en     = reg_cfg[0];
  assign cfg_fixed  = reg_cfg[1];
  assign cfg_clr    = reg_cfg[2];
  assign unused_cfg = ^reg_cfg[REG_DW-1:3];

  assign req_valid = {s_angle.tvalid, s_shift.tvalid, s_side.tvalid};

  // Payload of the currently granted source.
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_user  = '0;
    g_last  = 1'b0;
    case (grant)
      2'd0: begin
        g_valid = s_side.tvalid;
        g_data  = s_side.tdata;
        g_user  = s_side.tuser;
        g_last  = s_side.tlast;
      end
      2'd1: begin
        g_valid = s_shift.tvalid;
        g_data  = s_shift.tdata;
        g_user  = s_shift.tuser;
        g_last  = s_shift.tlast;
      end
      2'd2: begin
        g_valid = s_angle.tvalid;
        g_data  = s_angle.tdata;
        g_user  = s_angle.tuser;
        g_last  = s_angle.tlast;
      end
      default: ;
    endcase
  end

  assign busy     = (state == ST_BUSY);
  // The single output stage can take a beat when empty or draining this cycle.
  assign out_free = ~out_valid | m_res.tready;
  assign accept   = busy & g_valid & out_free;
  assign beat_cap = (beat_cnt == CW'(MAXLEN - 1));
  assign pkt_end  = accept & (g_last | beat_cap);
  assign trunc    = accept & ~g_last & beat_cap;

  assign s_side.tready  = busy & (grant == 2'd0) & out_free;
  assign s_shift.tready = busy & (grant == 2'd1) & out_free;
  assign s_angle.tready = busy & (grant == 2'd2) & out_free;

  // Requester selection: fixed mode scans 0,1,2; round-robin scans starting
  // one past the last granted source.
  always_comb begin
    logic [1:0] idx;
    pick  = TID_NONE;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      idx = cfg_fixed ? 2'(i) : 2'((32'(rr_ptr) + i + 32'd1) % 32'd3);
      if (!found && req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      grant  <= TID_NONE;
      rr_ptr <= 2'd2;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    rr_next    = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (cfg_en && found) begin
          grant_next = pick;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Enable is not consulted here: an open packet always completes.
        if (pkt_end) begin
          grant_next = TID_NONE;
          rr_next    = grant;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = TID_NONE;
      end
    endcase
  end

  // Output register stage and per-packet beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= '0;
      out_last  <= 1'b0;
      out_tid   <= '0;
      beat_cnt  <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_user  <= g_user;
        out_last  <= g_last | beat_cap;
        out_tid   <= grant;
        beat_cnt  <= pkt_end ? '0 : beat_cnt + 1'b1;
      end else if (m_res.tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign m_res.tvalid = out_valid;
  assign m_res.tdata  = out_data;
  assign m_res.tuser  = out_user;
  assign m_res.tlast  = out_last;
  assign m_res.tid    = out_tid;

  assign inc[0] = accept & (grant == 2'd0);
  assign inc[1] = accept & (grant == 2'd1);
  assign inc[2] = accept & (grant == 2'd2);
  assign inc[3] = out_valid & m_res.tready & out_last;

  // Statistics; clear only touches these, never the data path.
  always_ff @(posedge clk) begin
    if (rst || cfg_clr) begin
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
      err_trunc <= 1'b0;
      err_wrap  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (inc[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
          if (&cnt[i]) err_wrap <= 1'b1;
        end
      end
      if (trunc) err_trunc <= 1'b1;
    end
  end

  assign reg_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
  assign reg_sta = {{(REG_DW-4){1'b0}}, out_valid & ~m_res.tready, busy, grant};
  assign reg_err = {{(REG_DW-2){1'b0}}, err_wrap, err_trunc};

endmodule
